grid_clb_bl_wl_loader: RTL and testbench



---
 rtl/grid_clb_bl_wl_loader.sv | 157 +++++++++++++++
 tb/tb_grid_clb_bl_wl_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_clb_bl_wl_loader.sv
// Configuration loader for one grid_clb tile's memory bank.
// Assembles a bit-line frame from a valid/ready beat stream, then strobes one
// word line per row. bl/wl connect straight to the tile's bl/wl inputs.
module grid_clb_bl_wl_loader #(
  parameter int NUM_BL   = 1020,
  parameter int NUM_WL   = 1,
  parameter int DATA_W   = 4,
  parameter int WL_PULSE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl
);

  localparam int BEATS   = NUM_BL / DATA_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W   = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int PULSE_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
  localparam int IDX_W   = (NUM_BL > 1) ? $clog2(NUM_BL) : 1;

  localparam logic [IDX_W-1:0]   DW_IDX     = IDX_W'(DATA_W);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_WL - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(WL_PULSE - 1);

  // A frame that is not a whole number of beats, or a zero-length pulse,
  // cannot be programmed correctly, so refuse to elaborate.
  if ((NUM_BL % DATA_W) != 0) begin : g_bad_frame
    $error("grid_clb_bl_wl_loader: NUM_BL must be a multiple of DATA_W");
  end
  if (WL_PULSE < 1) begin : g_bad_pulse
    $error("grid_clb_bl_wl_loader: WL_PULSE must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [ROW_W-1:0]     row_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [PULSE_W-1:0]   pulse_q;
  logic [0:NUM_BL-1]    bl_q;
  logic [0:NUM_WL-1]    wl_q;
  logic                 done_q;

  logic [DATA_W-1:0]    data_rev;
  logic [0:NUM_WL-1]    row_onehot;
  logic [IDX_W-1:0]     base_idx;

  // Beat bit i lands on bl[k*DATA_W + i]; bl is ascending, so the beat is
  // bit-reversed to make a plain part-select put cfg_data[0] first.
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_rev[DATA_W-1-i] = cfg_data[i];
    end
  end

  // Decode the current row into the word line it should strobe.
  always_comb begin
    row_onehot = '0;
    for (int r = 0; r < NUM_WL; r++) begin
      row_onehot[r] = (row_q == ROW_W'(r));
    end
  end

  assign base_idx = IDX_W'(beat_q) * DW_IDX;

  // Whole programming sequence: load a frame, bracket a word-line pulse with
  // one quiet cycle on each side, then advance to the next row or finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      beat_q  <= '0;
      pulse_q <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg_start) begin
            state_q <= S_LOAD;
            row_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            bl_q[base_idx +: DATA_W] <= data_rev;
            if (beat_q == BEAT_LAST) begin
              state_q <= S_SETUP;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        S_SETUP: begin
          state_q <= S_PULSE;
          pulse_q <= '0;
          wl_q    <= row_onehot;
        end
        S_PULSE: begin
          if (pulse_q == PULSE_LAST) begin
            state_q <= S_HOLD;
            wl_q    <= '0;
          end else begin
            pulse_q <= pulse_q + PULSE_W'(1);
          end
        end
        S_HOLD: begin
          if (row_q == ROW_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_LOAD;
            row_q   <= row_q + ROW_W'(1);
            beat_q  <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wl_q    <= '0;
        end
      endcase
    end
  end

  assign cfg_ready = (state_q == S_LOAD);
  assign cfg_busy  = (state_q == S_LOAD) || (state_q == S_SETUP) ||
                     (state_q == S_PULSE) || (state_q == S_HOLD);
  assign cfg_done  = done_q;
  assign bl        = bl_q;
  assign wl        = wl_q;

  // The tile must never see two rows selected at once.
  a_wl_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(wl_q));

  // The frame must be frozen while a word line is writing it.
  a_bl_stable : assert property (@(posedge clk) disable iff (reset) (|wl_q) |=> $stable(bl_q));

endmodule

// File: tb/tb_grid_clb_bl_wl_loader.sv
// Self-checking bench for grid_clb_bl_wl_loader: a default-sized single-row
// instance and a small three-row instance, both compared every cycle against
// a timeline model of the programming pass.
module tb_grid_clb_bl_wl_loader;

  logic clk = 1'b0;
  logic reset;

  logic       startA, validA;
  logic [3:0] dataA;
  logic       readyA, busyA, doneA;
  logic [0:1019] blA;
  logic [0:0]    wlA;

  logic       startB, validB;
  logic [3:0] dataB;
  logic       readyB, busyB, doneB;
  logic [0:7] blB;
  logic [0:2] wlB;

  int nChecks = 0;
  int nPass   = 0;

  // Model state: a pass is active, which row, beats taken in this row, and
  // edges elapsed since the row's last beat (-1 while still loading).
  bit  actA, dnA, actB, dnB;
  int  beatsA, rowA, sinceA, beatsB, rowB, sinceB;
  logic [0:1019] frA, frB;
  logic [0:0] ewA;
  logic [0:2] ewB;

  grid_clb_bl_wl_loader #(
    .NUM_BL(1020), .NUM_WL(1), .DATA_W(4), .WL_PULSE(2)
  ) dutA (
    .clk(clk), .reset(reset), .cfg_start(startA), .cfg_data(dataA),
    .cfg_valid(validA), .cfg_ready(readyA), .cfg_busy(busyA),
    .cfg_done(doneA), .bl(blA), .wl(wlA)
  );

  grid_clb_bl_wl_loader #(
    .NUM_BL(8), .NUM_WL(3), .DATA_W(4), .WL_PULSE(3)
  ) dutB (
    .clk(clk), .reset(reset), .cfg_start(startB), .cfg_data(dataB),
    .cfg_valid(validB), .cfg_ready(readyB), .cfg_busy(busyB),
    .cfg_done(doneB), .bl(blB), .wl(wlB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [1023:0] act,
                             input logic [1023:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One edge of the behavioural model, driven purely by the timeline rules.
  task automatic modelStep(input int nbl, input int dw, input int nwl, input int p,
                           input logic rst, input logic st, input logic vld,
                           input logic [3:0] d,
                           inout bit act, inout bit dn, inout int beats,
                           inout int row, inout int since,
                           inout logic [0:1019] frame);
    if (rst) begin
      act = 0; dn = 0; beats = 0; row = 0; since = -1; frame = '0;
    end else if (!act) begin
      if (st) begin
        act = 1; dn = 0; beats = 0; row = 0; since = -1;
      end
    end else if (since < 0) begin
      if (vld) begin
        for (int i = 0; i < dw; i++) frame[beats*dw + i] = d[i];
        beats++;
        if (beats == nbl / dw) since = 0;
      end
    end else begin
      since++;
      if (since == p + 2) begin
        if (row == nwl - 1) begin
          act = 0; dn = 1;
        end else begin
          row++; beats = 0; since = -1;
        end
      end
    end
  endtask

  // Advance the model on each edge and compare every output shortly after.
  always begin
    @(posedge clk);
    modelStep(1020, 4, 1, 2, reset, startA, validA, dataA,
              actA, dnA, beatsA, rowA, sinceA, frA);
    modelStep(8, 4, 3, 3, reset, startB, validB, dataB,
              actB, dnB, beatsB, rowB, sinceB, frB);
    #1;
    ewA = '0;
    if (actA && sinceA >= 1 && sinceA <= 2) ewA[rowA] = 1'b1;
    ewB = '0;
    if (actB && sinceB >= 1 && sinceB <= 3) ewB[rowB] = 1'b1;
    checkOutput("A.bl", blA, frA);
    checkOutput("A.wl", wlA, ewA);
    checkOutput("A.ready", readyA, actA && sinceA < 0);
    checkOutput("A.busy", busyA, actA);
    checkOutput("A.done", doneA, dnA);
    checkOutput("B.bl", blB, frB[0:7]);
    checkOutput("B.wl", wlB, ewB);
    checkOutput("B.ready", readyB, actB && sinceB < 0);
    checkOutput("B.busy", busyB, actB);
    checkOutput("B.done", doneB, dnB);
  end

  // Drive one cycle of inputs (called at a falling edge, returns at the next).
  task automatic applyStimulus(input bit rst, input bit sA, input bit vA,
                               input logic [3:0] dA, input bit sB, input bit vB,
                               input logic [3:0] dB);
    reset = rst; startA = sA; validA = vA; dataA = dA;
    startB = sB; validB = vB; dataB = dB;
    @(negedge clk);
  endtask

  task automatic streamRowB(input logic [7:0] rowByte, input bit noisyStart);
    int k, guard;
    bit v, take;
    k = 0; guard = 0;
    while (k < 2 && guard < 200) begin
      v    = ($urandom_range(0, 2) != 0);
      take = v && readyB;
      applyStimulus(0, 0, 0, 4'h0, noisyStart && (k == 1), v,
                    (k == 0) ? rowByte[3:0] : rowByte[7:4]);
      if (take) k++;
      guard++;
    end
    checkOutput("B.loadBound", guard < 200, 1);
  endtask

  task automatic runPulseB(input int r, input bit noisyStart, output int hi);
    int guard;
    hi = 0; guard = 0;
    while (!(readyB || doneB) && guard < 30) begin
      applyStimulus(0, 0, 0, 4'h0, noisyStart && (wlB != 3'b000),
                    1'($urandom_range(0, 1)), 4'($urandom));
      if (wlB[r]) hi++;
      guard++;
    end
    checkOutput("B.pulseBound", guard < 30, 1);
  endtask

  task automatic fullPassB(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit noisy);
    logic [7:0] rows[3];
    logic [0:7] e;
    int hi;
    rows = '{b0, b1, b2};
    applyStimulus(0, 0, 0, 4'h0, 1, 1'($urandom_range(0, 1)), 4'($urandom));
    checkOutput("B.doneClearedOnStart", doneB, 0);
    checkOutput("B.readyOnStart", readyB, 1);
    for (int r = 0; r < 3; r++) begin
      streamRowB(rows[r], noisy);
      for (int i = 0; i < 8; i++) e[i] = rows[r][i];
      checkOutput("B.frame", blB, e);
      runPulseB(r, noisy, hi);
      checkOutput("B.wlWidth", hi, 3);
    end
    checkOutput("B.doneAtEnd", doneB, 1);
    checkOutput("B.idleAtEnd", busyB, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:1019] patA;
    logic [7:0] litBytes[3];
    logic [7:0] litFrames[3];
    int cyc, hiA, hi, guard;

    reset = 1'b1; startA = 0; validA = 0; dataA = 0;
    startB = 0; validB = 0; dataB = 0;
    @(negedge clk);

    // Reset held with start and valid asserted: nothing may happen.
    applyStimulus(1, 1, 1, 4'hF, 1, 1, 4'hF);
    applyStimulus(1, 1, 1, 4'hF, 1, 1, 4'hF);
    checkOutput("rst.blA", blA, 0);
    checkOutput("rst.wlA", wlA, 0);
    checkOutput("rst.busyA", busyA, 0);
    checkOutput("rst.readyA", readyA, 0);
    checkOutput("rst.doneA", doneA, 0);
    checkOutput("rst.blB", blB, 0);
    checkOutput("rst.wlB", wlB, 0);
    applyStimulus(0, 0, 1, 4'hF, 0, 1, 4'hF);
    checkOutput("idle.noConsumeA", blA, 0);
    checkOutput("idle.busyB", busyB, 0);

    // Default single row of 4'hA beats with no stalls.
    applyStimulus(0, 1, 1, 4'hA, 0, 0, 4'h0);
    checkOutput("A.readyAfterStart", readyA, 1);
    checkOutput("A.busyAfterStart", busyA, 1);
    cyc = 0; hiA = 0;
    while (!doneA && cyc < 400) begin
      applyStimulus(0, 0, 1, 4'hA, 0, 0, 4'h0);
      cyc++;
      if (wlA[0]) hiA++;
      if (cyc == 256) begin
        for (int i = 0; i < 1020; i++) patA[i] = (i % 2 == 1);
        checkOutput("A.framePattern", blA, patA);
      end
    end
    // Counted from the start edge: 255 beats + SETUP + 2 pulse + HOLD.
    checkOutput("A.startToDone", cyc, 259);
    checkOutput("A.wlWidth", hiA, 2);
    checkOutput("A.busyAtDone", busyA, 0);

    // Three literal rows with gaps, start pulsed in LOAD and in PULSE.
    litBytes  = '{8'h01, 8'h80, 8'hFF};
    litFrames = '{8'b1000_0000, 8'b0000_0001, 8'b1111_1111};
    applyStimulus(0, 0, 0, 4'h0, 1, 0, 4'h0);
    for (int r = 0; r < 3; r++) begin
      streamRowB(litBytes[r], r == 1);
      checkOutput("B.litFrame", blB, litFrames[r]);
      runPulseB(r, r == 0, hi);
      checkOutput("B.litWlWidth", hi, 3);
    end
    checkOutput("B.litDone", doneB, 1);

    // Reset while row 1 is being strobed, then a clean pass from row 0.
    applyStimulus(0, 0, 0, 4'h0, 1, 0, 4'h0);
    streamRowB(8'($urandom), 0);
    runPulseB(0, 0, hi);
    streamRowB(8'($urandom), 0);
    guard = 0;
    while (!wlB[1] && guard < 10) begin
      applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);
      guard++;
    end
    checkOutput("B.reachRow1Pulse", wlB, 3'b010);
    applyStimulus(1, 0, 0, 4'h0, 0, 1, 4'hF);
    checkOutput("B.rstMidWl", wlB, 0);
    checkOutput("B.rstMidBl", blB, 0);
    checkOutput("B.rstMidBusy", busyB, 0);
    applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);
    fullPassB(8'($urandom), 8'($urandom), 8'($urandom), 0);

    // Restart straight from DONE, then randomized passes with noise.
    fullPassB(8'h5A, 8'hC3, 8'h0F, 0);
    for (int p = 0; p < 4; p++) begin
      fullPassB(8'($urandom), 8'($urandom), 8'($urandom), 1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        applyStimulus(0, 0, 1'($urandom_range(0, 1)), 4'($urandom),
                      0, 1'($urandom_range(0, 1)), 4'($urandom));
    end

    applyStimulus(0, 0, 0, 4'h0, 0, 0, 4'h0);
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
